uart_tx: RTL
============

// Module: uart_tx
// PURPOSE
//  Serialiser directly downstream of the byte FIFO: pops bytes (data/have_next/next
//  handshake) and drives them onto the UART TX pin as 8N1 frames (optional parity).
//  Bit period comes from a runtime divisor written via CSR.
//  Sits between the FIFO and the top-level tx pad.
// PARAMETERS
//  DivWidth      16   width of baud divisor (clk cycles per bit)
//  FetchGuard    2    idle cycles after a pop before have_next_i is trusted again
// PORTS
//  clk_i        in   1         system clock
//  reset_i      in   1         reset: asynchronous, active-low
//  baud_div_i   in   DivWidth  clk cycles per bit; sampled at frame start; 0 treated as 1
//  have_next_i  in   1         FIFO holds >=1 byte (registered by FIFO, 1-cycle lag)
//  data_i       in   8         FIFO head byte, valid while have_next_i=1
//  next_o       out  1         1-cycle pop pulse to FIFO
//  tx_o         out  1         serial line, idle high
//  busy_o       out  1         high from pop until end of stop bit
// BEHAVIOUR
//  - Reset (async, reset_i=0): state=IDLE, tx_o=1, next_o=0, busy_o=0, guard=0,
//    shift reg=0, baud cnt=0, bit cnt=0. Reset mid-frame aborts immediately; line goes high.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - IDLE: when have_next_i=1 and guard==0: next_o=1 for exactly one cycle, data_i
//    latched into shift reg in that same cycle (head is valid before pop), div latched,
//    guard loaded with FetchGuard, busy_o=1, go START.
//  - All outputs registered: tx_o falls on the cycle after the next_o pulse.
//  - Every bit (start, 8 data LSB first, parity, 1 stop) held exactly div cycles;
//    baud cnt loads div-1 on bit entry, counts down, advances bit at 0.
//  - DATA: bit cnt 0..7; shift right on each bit boundary; after bit 7 -> PARITY/STOP.
//  - STOP: tx_o=1 for div cycles; then IDLE, busy_o=0 same edge.
//  - guard decrements every cycle to 0 (saturating); prevents double pop
//    while FIFO's have_next/buffer update lags. Only matters for div=1 frames.
//  - Back-to-back: if have_next_i=1 at STOP end and guard==0, the IDLE cycle
//    issues next_o; inter-frame gap = 1 idle cycle (tx_o high).
//  - baud_div_i changes mid-frame have no effect until next frame.
//  - next_o never asserted when have_next_i=0 (empty FIFO never popped).
// CONFIGURATION
//  UART_TX_PARITY_EN defined: adds PARITY state after DATA; ports parity_odd_i
//    (in, 1; 0=even, 1=odd, sampled at frame start); parity bit = ^byte ^ parity_odd_i;
//    frame = 11 bit periods.
//  Undefined: no PARITY state, no parity_odd_i port; frame = 10 bit periods.
// STRUCTURE
//  config_pkg: DivWidth default, UartDefaultDiv, BaudDivT (logic [DivWidth-1:0]).
//  decoder_pkg: UartBaudCsrAddr (CSR holding baud_div_i; register lives in CSR block).
//  uart_pkg (new): typedef enum UartTxStateT {IDLE,START,DATA,PARITY,STOP}.
//  Sub-module uart_baud_tick: loadable down-counter, emits bit_done pulse; FSM in uart_tx.
// TESTING
//  1. Reset: hold reset_i=0 mid-frame -> tx_o=1, next_o=0, busy_o=0 asynchronously;
//     release, have_next_i=0 -> line stays high, no pop.
//  2. Single byte 0xA5, div=4: one next_o pulse; tx_o = 0,1,0,1,0,0,1,0,1,1 each for
//     4 cycles (LSB first), start edge 1 cycle after pulse; busy_o low after 40 cycles.
//  3. Back-to-back 0x00,0xFF with have_next_i held 1, div=3: exactly 2 pops,
//     one idle-high cycle between frames, second frame correct.
//  4. div=1, FIFO model with 1-cycle have_next lag and 2 bytes queued: no double pop,
//     both bytes sent once, in order.
//  5. Change baud_div_i 4->8 mid-frame: current frame stays 4 cycles/bit,
//     next frame 8; baud_div_i=0 -> 1 cycle/bit.
//  6. UART_TX_PARITY_EN, 0x07, parity_odd_i=0, div=2: parity bit=1, stop follows;
//     parity_odd_i=1 -> parity bit=0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmitter
package uart_pkg;

  localparam int unsigned DivWidthDefault   = 16;
  localparam int unsigned FetchGuardDefault = 2;
  localparam int unsigned UartDefaultDiv    = 868;
  localparam logic [7:0]  UartBaudCsrAddr   = 8'h10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - loadable bit-period down-counter, bit_done_o while count is zero
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned DivWidth = DivWidthDefault
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic [DivWidth-1:0] load_val_i,
  output logic                bit_done_o
);

  logic [DivWidth-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - DivWidth'(1);
    end
  end

  assign bit_done_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART serialiser popping bytes from the TX FIFO
// Optional parity bit when UART_TX_PARITY_EN is defined.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DivWidth   = DivWidthDefault,
  parameter int unsigned FetchGuard = FetchGuardDefault
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [DivWidth-1:0] baud_div_i,
  input  logic                have_next_i,
  input  logic [7:0]          data_i,
`ifdef UART_TX_PARITY_EN
  input  logic                parity_odd_i,
`endif
  output logic                next_o,
  output logic                tx_o,
  output logic                busy_o
);

  localparam int unsigned GuardWidth = (FetchGuard > 0) ? $clog2(FetchGuard + 1) : 1;

  uart_tx_state_t        state_q, state_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [DivWidth-1:0]   div_q, div_d;
  logic [GuardWidth-1:0] guard_q, guard_d;
  logic                  tx_q, tx_d;
  logic                  next_q, next_d;
  logic                  busy_q, busy_d;
  logic                  baud_load;
  logic [DivWidth-1:0]   baud_load_val;
  logic                  bit_done;
  logic [DivWidth-1:0]   div_eff;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign div_eff = (baud_div_i == '0) ? DivWidth'(1) : baud_div_i;

  uart_baud_tick #(
    .DivWidth (DivWidth)
  ) u_baud_tick (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (baud_load),
    .load_val_i (baud_load_val),
    .bit_done_o (bit_done)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      div_q     <= DivWidth'(1);
      guard_q   <= '0;
      tx_q      <= 1'b1;
      next_q    <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      guard_q   <= guard_d;
      tx_q      <= tx_d;
      next_q    <= next_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // tx_d follows the current state, so the pin lags the FSM by one cycle throughout
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    div_d         = div_q;
    guard_d       = (guard_q != '0) ? guard_q - GuardWidth'(1) : '0;
    tx_d          = 1'b1;
    next_d        = 1'b0;
    busy_d        = busy_q;
    baud_load     = 1'b0;
    baud_load_val = div_q - DivWidth'(1);
`ifdef UART_TX_PARITY_EN
    parity_d      = parity_q;
`endif

    case (state_q)
      IDLE: begin
        if (have_next_i && (guard_q == '0)) begin
          next_d        = 1'b1;
          shift_d       = data_i;
          div_d         = div_eff;
          guard_d       = GuardWidth'(FetchGuard);
          busy_d        = 1'b1;
          bit_cnt_d     = '0;
          baud_load     = 1'b1;
          baud_load_val = div_eff - DivWidth'(1);
`ifdef UART_TX_PARITY_EN
          parity_d      = (^data_i) ^ parity_odd_i;
`endif
          state_d       = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_done) begin
          baud_load = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_done) begin
          baud_load = 1'b1;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef UART_TX_PARITY_EN
        tx_d = parity_q;
`endif
        if (bit_done) begin
          baud_load = 1'b1;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign next_o = next_q;
  assign tx_o   = tx_q;
  assign busy_o = busy_q;

endmodule
